// File: rtl/tartaruga_pkg.sv
// Shared types and helpers for the store queue: access sizes, queue entries,
// drain FSM states and the byte-enable/mask functions used by stores and loads.
package tartaruga_pkg;

    localparam int SQ_DATA_W     = 32;
    localparam int SQ_MAX_ADDR_W = 64;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } mem_size_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } sq_state_t;

    // addr holds the word-aligned byte address, zero-extended to the widest supported bus
    typedef struct packed {
        logic [SQ_MAX_ADDR_W-1:0] addr;
        logic [SQ_DATA_W-1:0]     data;
        logic [3:0]               be;
    } sq_entry_t;

    // Misaligned halfwords/words yield an empty byte enable
    function automatic logic [3:0] size_be(input logic [1:0] offset, input logic [1:0] size);
        logic [3:0] be;
        be = '0;
        case (size)
            SZ_BYTE: be = 4'b0001 << offset;
            SZ_HALF: if (!offset[0]) be = 4'b0011 << offset;
            SZ_WORD: if (offset == 2'd0) be = 4'hF;
            default: be = '0;
        endcase
        return be;
    endfunction

    function automatic logic [SQ_DATA_W-1:0] size_mask(input logic [1:0] size);
        logic [SQ_DATA_W-1:0] mask;
        mask = '1;
        case (size)
            SZ_BYTE: mask = 32'h0000_00FF;
            SZ_HALF: mask = 32'h0000_FFFF;
            default: mask = '1;
        endcase
        return mask;
    endfunction

endpackage

// File: rtl/store_align.sv
// Moves store data onto its byte lanes and builds the matching byte enable.
module store_align
    import tartaruga_pkg::*;
(
    input  logic [1:0]  offset,
    input  logic [1:0]  size,
    input  logic [31:0] wdata,
    output logic [31:0] lane_data,
    output logic [3:0]  be
);

    assign lane_data = wdata << {offset, 3'b000};
    assign be        = size_be(offset, size);

endmodule

// File: rtl/store_queue.sv
// Speculative store queue: enqueue, commit/discard, in-order drain to memory
// and combinational store-to-load forwarding across every live entry.
module store_queue
    import tartaruga_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     enq_valid_i,
    output logic                     enq_ready_o,
    input  logic [ADDR_W-1:0]        enq_addr_i,
    input  logic [DATA_W-1:0]        enq_data_i,
    input  logic [1:0]               enq_size_i,
    input  logic                     commit_i,
    input  logic                     discard_i,
    input  logic [ADDR_W-1:0]        ld_addr_i,
    input  logic [1:0]               ld_size_i,
    output logic                     fwd_hit_o,
    output logic [DATA_W-1:0]        fwd_data_o,
    output logic                     fwd_conflict_o,
    output logic                     mem_req_valid_o,
    input  logic                     mem_req_ready_i,
    output logic [ADDR_W-1:0]        mem_addr_o,
    output logic [DATA_W-1:0]        mem_data_o,
    output logic [3:0]               mem_be_o,
    input  logic                     mem_rsp_valid_i,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic [1:0]               state_o
);

    localparam int IW = $clog2(DEPTH);
    localparam int PW = IW + 1;

    // Handshakes: enq fires on enq_valid_i && enq_ready_o at the rising edge; a memory
    // request is accepted when mem_req_valid_o && mem_req_ready_i, and the request
    // outputs stay stable from the first valid cycle until that acceptance.

    logic [PW-1:0] head_q, cmt_q, tail_q;
    logic [PW-1:0] head_n, cmt_n, tail_n;
    sq_state_t     state_q, state_n;
    sq_entry_t     entries [DEPTH];

    logic          enq_fire;
    logic          free;
    logic [31:0]   enq_lane;
    logic [3:0]    enq_be;
    logic [IW-1:0] head_idx;

    assign head_idx = head_q[IW-1:0];
    assign count_o  = tail_q - head_q;
    assign full_o   = (count_o == PW'(DEPTH));
    assign empty_o  = (count_o == '0);
    assign state_o  = state_q;

    // Registered full flag only: a same-cycle free does not open the door
    assign enq_ready_o = !full_o && !discard_i;
    assign enq_fire    = enq_valid_i && enq_ready_o;

    store_align u_align (
        .offset    (enq_addr_i[1:0]),
        .size      (enq_size_i),
        .wdata     (enq_data_i),
        .lane_data (enq_lane),
        .be        (enq_be)
    );

    always_ff @(posedge clk_i) begin
        if (enq_fire) begin
            entries[tail_q[IW-1:0]].addr <= SQ_MAX_ADDR_W'({enq_addr_i[ADDR_W-1:2], 2'b00});
            entries[tail_q[IW-1:0]].data <= enq_lane;
            entries[tail_q[IW-1:0]].be   <= enq_be;
        end
    end

    // Commit resolves before discard, so a same-cycle pair keeps the newly committed entry
    always_comb begin
        cmt_n  = cmt_q;
        tail_n = tail_q;
        head_n = head_q;
        if (commit_i && (cmt_q != tail_q)) cmt_n = cmt_q + PW'(1);
        if (discard_i)     tail_n = cmt_n;
        else if (enq_fire) tail_n = tail_q + PW'(1);
        if (free)          head_n = head_q + PW'(1);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            head_q  <= '0;
            cmt_q   <= '0;
            tail_q  <= '0;
            state_q <= ST_IDLE;
        end else begin
            head_q  <= head_n;
            cmt_q   <= cmt_n;
            tail_q  <= tail_n;
            state_q <= state_n;
        end
    end

    // Drain only committed entries (head up to cmt); empty-enable stores retire without a request
    always_comb begin
        state_n         = state_q;
        free            = 1'b0;
        mem_req_valid_o = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (head_q != cmt_q) begin
                    if (entries[head_idx].be == 4'h0) free = 1'b1;
                    else                              state_n = ST_REQ;
                end
            end
            ST_REQ: begin
                mem_req_valid_o = 1'b1;
                if (mem_req_ready_i) state_n = ST_WAIT;
            end
            ST_WAIT: begin
                if (mem_rsp_valid_i) begin
                    free    = 1'b1;
                    state_n = ST_IDLE;
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    always_comb begin
        mem_addr_o = '0;
        mem_data_o = '0;
        mem_be_o   = '0;
        if (state_q == ST_REQ) begin
            mem_addr_o = entries[head_idx].addr[ADDR_W-1:0];
            mem_data_o = entries[head_idx].data;
            mem_be_o   = entries[head_idx].be;
        end
    end

    logic [SQ_MAX_ADDR_W-1:0] ld_waddr;
    logic [3:0]               ld_be;
    logic [IW-1:0]            fidx;
    logic [31:0]              fwd_raw;
    logic                     hit, conflict;

    assign ld_waddr = SQ_MAX_ADDR_W'({ld_addr_i[ADDR_W-1:2], 2'b00});
    assign ld_be    = size_be(ld_addr_i[1:0], ld_size_i);

    // Walk oldest to youngest: a full cover resets the verdict, a partial overlap poisons it
    always_comb begin
        hit      = 1'b0;
        conflict = 1'b0;
        fwd_raw  = '0;
        fidx     = '0;
        for (int i = 0; i < DEPTH; i++) begin
            fidx = head_idx + IW'(i);
            if ((PW'(i) < count_o) && (entries[fidx].addr == ld_waddr) &&
                ((entries[fidx].be & ld_be) != 4'h0)) begin
                if ((entries[fidx].be & ld_be) == ld_be) begin
                    hit      = 1'b1;
                    conflict = 1'b0;
                    fwd_raw  = entries[fidx].data;
                end else begin
                    hit      = 1'b0;
                    conflict = 1'b1;
                end
            end
        end
    end

    assign fwd_hit_o      = hit;
    assign fwd_conflict_o = conflict;
    assign fwd_data_o     = hit ? ((fwd_raw >> {ld_addr_i[1:0], 3'b000}) & size_mask(ld_size_i)) : '0;

endmodule

// File: tb/tb_store_queue.sv
// Directed bench for store_queue: drain, forwarding, full/discard, commit ordering and reset abort.
module tb_store_queue;

    localparam int DEPTH = 4;
    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enq_valid_i = 1'b0;
    logic        enq_ready_o;
    logic [31:0] enq_addr_i = '0;
    logic [31:0] enq_data_i = '0;
    logic [1:0]  enq_size_i = '0;
    logic        commit_i = 1'b0;
    logic        discard_i = 1'b0;
    logic [31:0] ld_addr_i = '0;
    logic [1:0]  ld_size_i = '0;
    logic        fwd_hit_o;
    logic [31:0] fwd_data_o;
    logic        fwd_conflict_o;
    logic        mem_req_valid_o;
    logic        mem_req_ready_i = 1'b1;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_data_o;
    logic [3:0]  mem_be_o;
    logic        mem_rsp_valid_i;
    logic        full_o;
    logic        empty_o;
    logic [2:0]  count_o;
    logic [1:0]  state_o;

    int          n_cmp = 0;
    int          n_bad = 0;
    int          req_cnt = 0;
    int          rsp_delay = 2;
    logic [67:0] exp_q[$];
    logic [67:0] exp_e;

    store_queue #(.DEPTH(DEPTH), .ADDR_W(32), .DATA_W(32)) dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .enq_valid_i     (enq_valid_i),
        .enq_ready_o     (enq_ready_o),
        .enq_addr_i      (enq_addr_i),
        .enq_data_i      (enq_data_i),
        .enq_size_i      (enq_size_i),
        .commit_i        (commit_i),
        .discard_i       (discard_i),
        .ld_addr_i       (ld_addr_i),
        .ld_size_i       (ld_size_i),
        .fwd_hit_o       (fwd_hit_o),
        .fwd_data_o      (fwd_data_o),
        .fwd_conflict_o  (fwd_conflict_o),
        .mem_req_valid_o (mem_req_valid_o),
        .mem_req_ready_i (mem_req_ready_i),
        .mem_addr_o      (mem_addr_o),
        .mem_data_o      (mem_data_o),
        .mem_be_o        (mem_be_o),
        .mem_rsp_valid_i (mem_rsp_valid_i),
        .full_o          (full_o),
        .empty_o         (empty_o),
        .count_o         (count_o),
        .state_o         (state_o)
    );

    // Clock / reset
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Driver tasks: each starts and ends just after a falling edge
    task automatic enq(input logic [31:0] a, input logic [31:0] d, input logic [1:0] s);
        enq_valid_i = 1'b1;
        enq_addr_i  = a;
        enq_data_i  = d;
        enq_size_i  = s;
        @(negedge clk);
        enq_valid_i = 1'b0;
    endtask

    task automatic do_commit();
        commit_i = 1'b1;
        @(negedge clk);
        commit_i = 1'b0;
    endtask

    task automatic do_discard();
        discard_i = 1'b1;
        @(negedge clk);
        discard_i = 1'b0;
    endtask

    task automatic probe(input string tag, input logic [31:0] a, input logic [1:0] s,
                         input logic hit, input logic conf, input logic [31:0] d);
        ld_addr_i = a;
        ld_size_i = s;
        #1;
        check({tag, "_hit"}, fwd_hit_o, hit);
        check({tag, "_conflict"}, fwd_conflict_o, conf);
        check({tag, "_data"}, fwd_data_o, d);
    endtask

    task automatic wait_empty(input string tag, input int budget);
        for (int k = 0; k < budget && !empty_o; k++) @(negedge clk);
        check(tag, empty_o, 1);
    endtask

    task automatic check_reset(input string p);
        check({p, "_req_valid"}, mem_req_valid_o, 0);
        check({p, "_addr"}, mem_addr_o, 0);
        check({p, "_data"}, mem_data_o, 0);
        check({p, "_be"}, mem_be_o, 0);
        check({p, "_empty"}, empty_o, 1);
        check({p, "_full"}, full_o, 0);
        check({p, "_count"}, count_o, 0);
        check({p, "_enq_ready"}, enq_ready_o, 1);
        check({p, "_state"}, state_o, 0);
    endtask

    task automatic expect_req(input logic [31:0] a, input logic [3:0] be, input logic [31:0] d);
        exp_q.push_back({a, be, d});
    endtask

    // Scoreboard + memory responder: compare each accepted request, ack after rsp_delay
    initial begin
        mem_rsp_valid_i = 1'b0;
        forever begin
            @(negedge clk);
            #2;
            if (!rst && mem_req_valid_o && mem_req_ready_i) begin
                req_cnt++;
                if (exp_q.size() == 0) begin
                    check("req_unexpected", 1, 0);
                end else begin
                    exp_e = exp_q.pop_front();
                    check("req_addr", mem_addr_o, exp_e[67:36]);
                    check("req_be", {28'b0, mem_be_o}, {28'b0, exp_e[35:32]});
                    check("req_data", mem_data_o, exp_e[31:0]);
                end
                @(posedge clk);
                repeat (rsp_delay) @(negedge clk);
                mem_rsp_valid_i = 1'b1;
                @(negedge clk);
                mem_rsp_valid_i = 1'b0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(negedge clk);
        #1;
        check_reset("rst0");
        rst = 1'b0;
        @(negedge clk);

        // Single committed word drains as one request
        expect_req(32'h100, 4'hF, 32'hDEADBEEF);
        enq(32'h100, 32'hDEADBEEF, SZ_W);
        check("t1_count", count_o, 1);
        check("t1_empty", empty_o, 0);
        do_commit();
        wait_empty("t1_drain", 30);
        check("t1_reqs", req_cnt, 1);

        // Byte store forwarding and partial-cover conflict
        enq(32'h103, 32'h000000AB, SZ_B);
        probe("t2_byte", 32'h103, SZ_B, 1, 0, 32'h000000AB);
        probe("t2_word", 32'h100, SZ_W, 0, 1, 32'h0);
        do_discard();
        check("t2_count", count_o, 0);

        // Fill without commit, try one more, then discard all
        for (int i = 0; i < DEPTH; i++) enq(32'h600 + 32'(4 * i), 32'(i), SZ_W);
        check("t3_full", full_o, 1);
        check("t3_ready", enq_ready_o, 0);
        check("t3_count", count_o, 4);
        enq(32'h700, 32'h77, SZ_W);
        check("t3_count_drop", count_o, 4);
        repeat (5) @(negedge clk);
        check("t3_no_req", req_cnt, 1);
        check("t3_idle", state_o, 0);
        do_discard();
        check("t3_count_clr", count_o, 0);
        check("t3_empty", empty_o, 1);
        check("t3_not_full", full_o, 0);

        // Three stores, commit one, discard (with a dropped enqueue alongside)
        expect_req(32'h300, 4'hF, 32'h1);
        enq(32'h300, 32'h1, SZ_W);
        enq(32'h304, 32'h2, SZ_W);
        enq(32'h308, 32'h3, SZ_W);
        do_commit();
        discard_i   = 1'b1;
        enq_valid_i = 1'b1;
        enq_addr_i  = 32'h30C;
        enq_data_i  = 32'h4;
        enq_size_i  = SZ_W;
        #1;
        check("t4_ready_discard", enq_ready_o, 0);
        @(negedge clk);
        discard_i   = 1'b0;
        enq_valid_i = 1'b0;
        check("t4_count_kept", count_o, 1);
        wait_empty("t4_drain", 30);
        repeat (6) @(negedge clk);
        check("t4_reqs", req_cnt, 2);
        check("t4_count", count_o, 0);

        // Commit and discard together keep exactly the oldest store
        expect_req(32'h340, 4'hF, 32'h44);
        enq(32'h340, 32'h44, SZ_W);
        enq(32'h344, 32'h55, SZ_W);
        commit_i  = 1'b1;
        discard_i = 1'b1;
        @(negedge clk);
        commit_i  = 1'b0;
        discard_i = 1'b0;
        check("t5_count", count_o, 1);
        wait_empty("t5_drain", 30);
        repeat (4) @(negedge clk);
        check("t5_reqs", req_cnt, 3);

        // Misaligned word: be=0, retires without a request
        enq(32'h351, 32'h99, SZ_W);
        check("t5b_count", count_o, 1);
        do_commit();
        wait_empty("t5b_drain", 10);
        repeat (4) @(negedge clk);
        check("t5b_reqs", req_cnt, 3);

        // Word then younger halfword on the same word
        enq(32'h200, 32'h11111111, SZ_W);
        enq(32'h202, 32'h00002222, SZ_H);
        probe("t6_word", 32'h200, SZ_W, 0, 1, 32'h0);
        probe("t6_half", 32'h202, SZ_H, 1, 0, 32'h00002222);
        probe("t6_byte1", 32'h201, SZ_B, 1, 0, 32'h00000011);
        probe("t6_byte3", 32'h203, SZ_B, 1, 0, 32'h00000022);
        probe("t6_miss", 32'h400, SZ_W, 0, 0, 32'h0);
        do_discard();
        check("t6_count", count_o, 0);

        // Back-pressure with stable outputs, then reset mid-WAIT
        mem_req_ready_i = 1'b0;
        rsp_delay       = 3;
        expect_req(32'h500, 4'hF, 32'hCAFEF00D);
        enq(32'h500, 32'hCAFEF00D, SZ_W);
        do_commit();
        for (int k = 0; k < 20 && !mem_req_valid_o; k++) @(negedge clk);
        check("t7_valid_seen", mem_req_valid_o, 1);
        for (int k = 0; k < 5; k++) begin
            check("t7_hold_valid", mem_req_valid_o, 1);
            check("t7_hold_addr", mem_addr_o, 32'h500);
            check("t7_hold_data", mem_data_o, 32'hCAFEF00D);
            check("t7_hold_be", {28'b0, mem_be_o}, 32'hF);
            @(negedge clk);
        end
        mem_req_ready_i = 1'b1;
        @(negedge clk);
        mem_req_ready_i = 1'b0;
        check("t7_wait", state_o, 2);
        rst = 1'b1;
        #1;
        check_reset("t7_rst");
        @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        check("t7_idle_after_rsp", state_o, 0);
        check("t7_valid_after_rsp", mem_req_valid_o, 0);
        check("t7_count_after_rsp", count_o, 0);
        check("t7_reqs", req_cnt, 4);
        check("t7_exp_left", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/store_queue.md
STORE_QUEUE -- requirements
Module: store_queue

Interface
REQ-001 Parameter DEPTH, 4: number of entries; power of two, 2..32.
REQ-002 Parameter ADDR_W, 32: address width.
REQ-003 Parameter DATA_W, 32: data width; fixed at 32 in this generation.
REQ-004 clk_i  in  1  clock; single clock domain, rising edge.
REQ-005 rst_i  in  1  asynchronous, active-high reset.
REQ-006 enq_valid_i/enq_ready_o  in/out  1  store enqueue handshake.
REQ-007 enq_addr_i  in  ADDR_W  byte address. enq_data_i  in  32  unaligned source data. enq_size_i  in  2  mem_size_t (BYTE, HALF, WORD).
REQ-008 commit_i  in  1  oldest speculative entry becomes committed.
REQ-009 discard_i  in  1  drop all speculative (uncommitted) entries.
REQ-010 ld_addr_i  in  ADDR_W, ld_size_i  in  2  load forwarding probe.
REQ-011 fwd_hit_o  out  1, fwd_data_o  out  32, fwd_conflict_o  out  1  forwarding result.
REQ-012 mem_req_valid_o/mem_req_ready_i  out/in  1; mem_addr_o  out  ADDR_W (word-aligned); mem_data_o  out  32; mem_be_o  out  4.
REQ-013 mem_rsp_valid_i  in  1  write acknowledge.
REQ-014 full_o, empty_o  out  1; count_o  out  $clog2(DEPTH)+1.

Function
REQ-015 Circular FIFO with three pointers: head (oldest), cmt (first speculative entry), tail (next free); pointers carry one extra wrap bit.
REQ-016 Enqueue fires on enq_valid_i && enq_ready_o; enq_ready_o = !full && !discard_i.
REQ-017 On enqueue, data is lane-shifted by addr[1:0] and a byte enable is built: BYTE 1<<a, HALF 3<<a, WORD 4'hF; a misaligned HALF/WORD is enqueued with be=0 and never written.
REQ-018 commit_i advances cmt by one when cmt != tail; otherwise it is ignored.
REQ-019 discard_i sets tail to cmt in the same cycle; an enqueue in that cycle is dropped; committed entries are kept.
REQ-020 commit_i and discard_i in the same cycle: commit first, then discard of the remainder.
REQ-021 Drain FSM states and transitions:
- IDLE -> REQ when head != cmt.
- REQ: mem_req_valid_o=1, outputs driven from entry[head], held stable until mem_req_ready_i; handshake -> WAIT.
- WAIT -> IDLE on mem_rsp_valid_i, which frees head (head+1).
- Entries with be=0 skip the request: freed directly from IDLE in one cycle.
REQ-022 Speculative entries are never drained.
REQ-023 Forwarding is combinational and scans all valid entries between head and tail, including in-flight ones.
REQ-024 Youngest overlapping entry whose bytes fully cover the load bytes -> fwd_hit_o=1 and fwd_data_o = that data shifted down to bit 0.
REQ-025 Any overlapping entry younger than the covering one (or any overlap with no full cover) -> fwd_conflict_o=1, fwd_hit_o=0.
REQ-026 No overlap -> fwd_hit_o=0, fwd_conflict_o=0, fwd_data_o=0.
REQ-027 Enqueue and free in the same cycle while full: free is counted first, but enq_ready_o still reflects the registered full flag (no bypass).
REQ-028 count_o = tail-head; full_o when count_o==DEPTH; empty_o when count_o==0.

Reset
REQ-029 rst_i asserted: all pointers 0, FSM in IDLE, mem_req_valid_o=0, mem_addr_o/data/be=0, empty_o=1, full_o=0, count_o=0, enq_ready_o=1.
REQ-030 Reset during REQ/WAIT abandons the transaction; a later mem_rsp_valid_i in IDLE is ignored.

Structure
REQ-031 mem_size_t, sq_entry_t (addr, data, be) and sq_state_t go in tartaruga_pkg.
REQ-032 Lane shift / byte-enable logic is one sub-module, store_align.

Verification
REQ-033 Enqueue WORD 0x100=0xDEADBEEF, commit, ready=1, rsp after 2 cycles -> one request addr 0x100, be 4'hF, data 0xDEADBEEF; empty_o=1 afterwards.
REQ-034 Enqueue BYTE 0x103=0xAB, probe ld BYTE 0x103 -> fwd_hit_o=1, fwd_data_o=0x000000AB; probe WORD 0x100 -> fwd_conflict_o=1.
REQ-035 Enqueue DEPTH stores without commit -> full_o=1, enq_ready_o=0, no mem request; discard_i -> count_o=0 next cycle.
REQ-036 Three stores, commit one, discard -> exactly one request issued, count_o ends at 0.
REQ-037 Stores WORD 0x200=0x11111111 then HALF 0x202=0x2222; ld WORD 0x200 -> conflict; ld HALF 0x202 -> hit, data 0x00002222.
REQ-038 Hold mem_req_ready_i=0 for 5 cycles with outputs checked stable, then assert rst_i mid-WAIT -> all outputs at reset values.
